// File: rtl/screensaver_pkg.sv
// Shared definitions for the logo screensaver: default geometry, palette size,
// motion FSM states and the per-axis direction type.
package screensaver_pkg;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned LOGO_W     = 128;
    localparam int unsigned LOGO_H     = 128;
    localparam int unsigned NUM_COLORS = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_X = 2'd1,
        STEP_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/logo_motion_ctrl_axis_step.sv
// Combinational next-position for one axis: advance by step, clamp to [0, MAX]
// and reflect when an edge is reached or crossed.
module axis_step
    import screensaver_pkg::*;
#(
    parameter int unsigned MAX = 512
) (
    input  logic [9:0] pos,
    input  logic [2:0] step,
    input  dir_t       dir,
    output logic [9:0] npos,
    output logic       hit,
    output dir_t       ndir
);

    localparam logic [10:0] MAX_W = 11'(MAX);

    logic [10:0] sum_s;
    logic [10:0] pos_w_s;
    logic [10:0] step_w_s;

    // Evaluated at 11 bits so an overshoot past MAX never wraps.
    always_comb begin
        pos_w_s  = {1'b0, pos};
        step_w_s = {8'd0, step};
        sum_s    = pos_w_s + step_w_s;
        npos     = pos;
        hit      = 1'b0;
        ndir     = dir;
        if (dir == POS) begin
            if (sum_s >= MAX_W) begin
                npos = MAX_W[9:0];
                hit  = 1'b1;
                ndir = NEG;
            end else begin
                npos = sum_s[9:0];
            end
        end else begin
            if (pos_w_s <= step_w_s) begin
                npos = 10'd0;
                hit  = 1'b1;
                ndir = POS;
            end else begin
                npos = pos - {7'd0, step};
            end
        end
    end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Per-frame logo motion controller: on each accepted frame tick, steps x then y,
// reflects off the active-area edges and advances the palette on every bounce.
module logo_motion_ctrl
    import screensaver_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = screensaver_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE   = screensaver_pkg::V_ACTIVE,
    parameter int unsigned LOGO_W     = screensaver_pkg::LOGO_W,
    parameter int unsigned LOGO_H     = screensaver_pkg::LOGO_H,
    parameter int unsigned X0         = 0,
    parameter int unsigned Y0         = 0,
    parameter int unsigned NUM_COLORS = screensaver_pkg::NUM_COLORS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] color_idx,
    output logic       bounce,
    output logic       corner,
    output logic       busy
);

    localparam int unsigned XMAX     = H_ACTIVE - LOGO_W;
    localparam int unsigned YMAX     = V_ACTIVE - LOGO_H;
    localparam logic [2:0]  COLOR_LAST = 3'(NUM_COLORS - 1);

    state_t     state_r;
    logic [2:0] step_r;
    logic [9:0] x_r, y_r, nx_r, ny_r;
    dir_t       dir_x_r, dir_y_r;
    logic       hit_x_r, hit_y_r;
    logic [2:0] color_r;
    logic       bounce_r, corner_r, busy_r;

    logic [9:0] nx_s, ny_s;
    logic       hx_s, hy_s;
    dir_t       ndx_s, ndy_s;

    axis_step #(.MAX(XMAX)) u_step_x (
        .pos  (x_r),
        .step (step_r),
        .dir  (dir_x_r),
        .npos (nx_s),
        .hit  (hx_s),
        .ndir (ndx_s)
    );

    axis_step #(.MAX(YMAX)) u_step_y (
        .pos  (y_r),
        .step (step_r),
        .dir  (dir_y_r),
        .npos (ny_s),
        .hit  (hy_s),
        .ndir (ndy_s)
    );

    // Motion FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            step_r   <= 3'd1;
            x_r      <= 10'(X0);
            y_r      <= 10'(Y0);
            nx_r     <= 10'(X0);
            ny_r     <= 10'(Y0);
            dir_x_r  <= POS;
            dir_y_r  <= POS;
            hit_x_r  <= 1'b0;
            hit_y_r  <= 1'b0;
            color_r  <= 3'd0;
            bounce_r <= 1'b0;
            corner_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            bounce_r <= 1'b0;
            corner_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_tick && !pause) begin
                        step_r  <= {1'b0, speed} + 3'd1;
                        busy_r  <= 1'b1;
                        state_r <= STEP_X;
                    end
                end
                STEP_X: begin
                    nx_r    <= nx_s;
                    hit_x_r <= hx_s;
                    dir_x_r <= ndx_s;
                    state_r <= STEP_Y;
                end
                STEP_Y: begin
                    ny_r    <= ny_s;
                    hit_y_r <= hy_s;
                    dir_y_r <= ndy_s;
                    state_r <= COMMIT;
                end
                COMMIT: begin
                    x_r <= nx_r;
                    y_r <= ny_r;
                    if (hit_x_r || hit_y_r) begin
                        color_r  <= (color_r == COLOR_LAST) ? 3'd0 : color_r + 3'd1;
                        bounce_r <= 1'b1;
                    end
                    corner_r <= hit_x_r & hit_y_r;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign x_pos     = x_r;
    assign y_pos     = y_r;
    assign color_idx = color_r;
    assign bounce    = bounce_r;
    assign corner    = corner_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Directed self-checking bench for logo_motion_ctrl; three instances differ only
// in reset position so edge and corner cases start where they need to.
module tb_logo_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] speed = 2'd0;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [2:0] c_a, c_b, c_c;
    logic       b_a, b_b, b_c, k_a, k_b, k_c, busy_a, busy_b, busy_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logo_motion_ctrl #(.X0(0), .Y0(0)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause), .speed(speed),
        .x_pos(x_a), .y_pos(y_a), .color_idx(c_a), .bounce(b_a), .corner(k_a), .busy(busy_a)
    );

    logo_motion_ctrl #(.X0(510), .Y0(0)) dut_xb (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause), .speed(speed),
        .x_pos(x_b), .y_pos(y_b), .color_idx(c_b), .bounce(b_b), .corner(k_b), .busy(busy_b)
    );

    logo_motion_ctrl #(.X0(511), .Y0(351)) dut_cn (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause), .speed(speed),
        .x_pos(x_c), .y_pos(y_c), .color_idx(c_c), .bounce(b_c), .corner(k_c), .busy(busy_c)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse frame_tick for one cycle; returns at the negedge inside T+1.
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Tick and return at the negedge inside T+4, where results and pulses are visible.
    task automatic tick_wait();
        do_tick();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        pause = 1'b0;
        do_reset();
        n_tests++;
        if (x_a !== 10'd0 || y_a !== 10'd0 || c_a !== 3'd0 || busy_a !== 1'b0 || b_a !== 1'b0 || k_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got x=%0d y=%0d c=%0d busy=%0b b=%0b k=%0b, want 0 0 0 0 0 0", x_a, y_a, c_a, busy_a, b_a, k_a);
        end
        speed = 2'd3;
        tick_wait();
        n_tests++;
        if (x_a !== 10'd4 || y_a !== 10'd4) begin
            n_fail++;
            $display("FAIL reset_premove: got (%0d,%0d), want (4,4)", x_a, y_a);
        end
        do_tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (x_a !== 10'd0 || y_a !== 10'd0 || c_a !== 3'd0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got x=%0d y=%0d c=%0d busy=%0b, want 0 0 0 0", x_a, y_a, c_a, busy_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        speed = 2'd0;
        tick_wait();
        n_tests++;
        if (x_a !== 10'd1 || y_a !== 10'd1 || b_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume: got (%0d,%0d) b=%0b, want (1,1) b=0", x_a, y_a, b_a);
        end
    endtask

    task automatic test_free_motion();
        do_reset();
        speed = 2'd3;
        do_tick();
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_t1: got %0b, want 1", busy_a);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b1 || x_a !== 10'd0) begin
            n_fail++;
            $display("FAIL busy_t3: got busy=%0b x=%0d, want busy=1 x=0", busy_a, x_a);
        end
        @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b0 || x_a !== 10'd4 || y_a !== 10'd4) begin
            n_fail++;
            $display("FAIL latency_t4: got busy=%0b (%0d,%0d), want busy=0 (4,4)", busy_a, x_a, y_a);
        end
        for (int i = 1; i < 10; i++) begin
            tick_wait();
            n_tests++;
            if (b_a !== 1'b0) begin
                n_fail++;
                $display("FAIL free_no_bounce: tick %0d got bounce=%0b, want 0", i, b_a);
            end
        end
        n_tests++;
        if (x_a !== 10'd40 || y_a !== 10'd40 || c_a !== 3'd0) begin
            n_fail++;
            $display("FAIL free_motion: got (%0d,%0d) c=%0d, want (40,40) c=0", x_a, y_a, c_a);
        end
    endtask

    task automatic test_x_bounce();
        do_reset();
        speed = 2'd3;
        tick_wait();
        n_tests++;
        if (x_b !== 10'd512 || y_b !== 10'd4 || b_b !== 1'b1 || k_b !== 1'b0 || c_b !== 3'd1) begin
            n_fail++;
            $display("FAIL x_bounce: got x=%0d y=%0d b=%0b k=%0b c=%0d, want 512 4 1 0 1", x_b, y_b, b_b, k_b, c_b);
        end
        @(negedge clk);
        n_tests++;
        if (b_b !== 1'b0) begin
            n_fail++;
            $display("FAIL x_bounce_pulse: got bounce=%0b one cycle later, want 0", b_b);
        end
        tick_wait();
        n_tests++;
        if (x_b !== 10'd508 || y_b !== 10'd8 || b_b !== 1'b0 || c_b !== 3'd1) begin
            n_fail++;
            $display("FAIL x_reflect: got x=%0d y=%0d b=%0b c=%0d, want 508 8 0 1", x_b, y_b, b_b, c_b);
        end
    endtask

    task automatic test_corner();
        do_reset();
        speed = 2'd0;
        tick_wait();
        n_tests++;
        if (x_c !== 10'd512 || y_c !== 10'd352 || b_c !== 1'b1 || k_c !== 1'b1 || c_c !== 3'd1) begin
            n_fail++;
            $display("FAIL corner: got (%0d,%0d) b=%0b k=%0b c=%0d, want (512,352) 1 1 1", x_c, y_c, b_c, k_c, c_c);
        end
        @(negedge clk);
        n_tests++;
        if (b_c !== 1'b0 || k_c !== 1'b0) begin
            n_fail++;
            $display("FAIL corner_pulse: got b=%0b k=%0b one cycle later, want 0 0", b_c, k_c);
        end
        tick_wait();
        n_tests++;
        if (x_c !== 10'd511 || y_c !== 10'd351 || b_c !== 1'b0 || c_c !== 3'd1) begin
            n_fail++;
            $display("FAIL corner_reflect: got (%0d,%0d) b=%0b c=%0d, want (511,351) 0 1", x_c, y_c, b_c, c_c);
        end
    endtask

    task automatic test_pause_drop();
        do_reset();
        speed = 2'd1;
        pause = 1'b1;
        do_tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (busy_a !== 1'b0 || x_a !== 10'd0 || y_a !== 10'd0) begin
                n_fail++;
                $display("FAIL pause: cycle %0d got busy=%0b (%0d,%0d), want 0 (0,0)", i, busy_a, x_a, y_a);
            end
            @(negedge clk);
        end
        pause = 1'b0;
        do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        n_tests++;
        if (x_a !== 10'd2 || y_a !== 10'd2 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_result: got (%0d,%0d) busy=%0b, want (2,2) 0", x_a, y_a, busy_a);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (busy_a !== 1'b0 || x_a !== 10'd2) begin
                n_fail++;
                $display("FAIL drop_ignored: cycle %0d got busy=%0b x=%0d, want 0 2", i, busy_a, x_a);
            end
        end
    endtask

    task automatic test_palette_wrap();
        int ticks;
        logic [2:0] want;
        do_reset();
        speed = 2'd3;
        for (int k = 1; k <= 7; k++) begin
            want = 3'(k % 7);
            ticks = 0;
            do begin
                tick_wait();
                ticks++;
            end while (b_a !== 1'b1 && ticks < 300);
            n_tests++;
            if (b_a !== 1'b1 || c_a !== want) begin
                n_fail++;
                $display("FAIL palette_wrap: bounce %0d got b=%0b c=%0d after %0d ticks, want b=1 c=%0d", k, b_a, c_a, ticks, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_motion();
        test_x_bounce();
        test_corner();
        test_pause_drop();
        test_palette_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logo_motion_ctrl.md
# logo_motion_ctrl

Per-frame motion controller for the logo screensaver. Once per video frame it advances the logo's top-left coordinate by a programmable step, reflects off the active-area edges, and advances the palette index on every bounce. The VGA timing generator drives `frame_tick`. The pixel renderer consumes `x_pos`, `y_pos` and `color_idx`, which are stable for the whole active frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in lines.
- `LOGO_W`, 128: logo width in pixels.
- `LOGO_H`, 128: logo height in lines.
- `X0`, 0: reset x position.
- `Y0`, 0: reset y position.
- `NUM_COLORS`, 7: palette size; `color_idx` wraps modulo this value.

Ports:
- `clk`  in  1: system clock (pixel clock).
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `frame_tick`  in  1: single-cycle pulse at the start of vertical blanking.
- `pause`  in  1: when high at tick, no motion occurs.
- `speed`  in  2: step per frame = `speed`+1 pixels, on both axes.
- `x_pos`  out  10: logo left edge, range 0..H_ACTIVE-LOGO_W.
- `y_pos`  out  10: logo top edge, range 0..V_ACTIVE-LOGO_H.
- `color_idx`  out  3: palette index, range 0..NUM_COLORS-1.
- `bounce`  out  1: one-cycle pulse when a frame update reflected on either axis.
- `corner`  out  1: one-cycle pulse when both axes reflected in the same update.
- `busy`  out  1: high while an update is in progress.

## Operation
- Reset values:
  - `x_pos`=X0, `y_pos`=Y0.
  - Internal direction: right and down.
  - `color_idx`=0; `bounce`=`corner`=`busy`=0.
  - FSM in IDLE.
- FSM states: IDLE -> STEP_X -> STEP_Y -> COMMIT -> IDLE.
- **IDLE**:
  - On `frame_tick`=1 with `pause`=0: latch `speed` into a step register and go to STEP_X.
  - With `pause`=1 the tick is ignored; stay in IDLE.
- **STEP_X**: compute `nx` at 11 bits unsigned (no wrap); `XMAX`=H_ACTIVE-LOGO_W.
  - Moving right: if x+step ≥ XMAX, then `nx`=XMAX, flip direction, set `hit_x`; else `nx`=x+step.
  - Moving left: if x ≤ step, then `nx`=0, flip direction, set `hit_x`; else `nx`=x−step.
  - Landing exactly on an edge counts as a hit.
- **STEP_Y**: same rule with `YMAX`=V_ACTIVE-LOGO_H and down/up, producing `ny` and `hit_y`.
- **COMMIT**:
  - Register `x_pos`←`nx` and `y_pos`←`ny`.
  - If `hit_x` or `hit_y`: `color_idx`←(`color_idx`+1) mod NUM_COLORS; pulse `bounce`.
  - If both hits: pulse `corner` as well. The colour still advances by exactly one.
  - Go to IDLE.
- `busy`=1 in STEP_X, STEP_Y and COMMIT.
- A `frame_tick` while `busy` is dropped: no queueing, no error.
- `speed` is sampled only at the accepting tick, so mid-update changes have no effect.
- Asserting reset mid-update aborts the update. All outputs return to reset values immediately (async).

## Timing
- Tick accepted in cycle T (IDLE). STEP_X runs in T+1, STEP_Y in T+2, COMMIT in T+3.
- New `x_pos`/`y_pos`/`color_idx` are visible from T+4.
- `bounce`/`corner` are high during T+4 only.
- `busy` is high during T+1..T+3.
- All outputs are registered; no combinational path from inputs to outputs.
- Update latency (3 cycles) is far shorter than the vertical blanking interval, so outputs never change during active video.

## Structure
- Shared package `screensaver_pkg` holds:
  - Geometry constants `H_ACTIVE`, `V_ACTIVE`, `LOGO_W`, `LOGO_H`.
  - `NUM_COLORS`.
  - The FSM state enum (IDLE, STEP_X, STEP_Y, COMMIT).
  - A `dir_t` type (POS/NEG).
- One sub-module is natural: `axis_step`. It is instantiated twice: combinational next-position/hit/flip for one axis, parameterised by axis maximum.
- Sharing a single instance time-multiplexed across STEP_X/STEP_Y is also acceptable.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-update (in STEP_Y).
  - Response: outputs immediately X0/Y0/0, `busy`=0. After release, the next tick moves from (X0,Y0).
- **Free motion:**
  - Stimulus: X0=Y0=0, `speed`=3, ten ticks.
  - Response: position (40,40), `color_idx`=0, no `bounce`.
- **X bounce:**
  - Stimulus: start x=510 moving right, `speed`=3.
  - Response: x=512, `bounce` pulse, `color_idx` 0→1. Next tick gives x=508.
- **Corner:**
  - Stimulus: start (511,351) down-right, `speed`=0.
  - Response: (512,352), `bounce`=`corner`=1 for one cycle, `color_idx` +1 only. Next tick gives (511,351).
- **Pause/drop:**
  - Stimulus: tick with `pause`=1, then a tick during `busy`.
  - Response: position unchanged both times; `busy` never asserted by them.
- **Palette wrap:**
  - Stimulus: force 7 bounces.
  - Response: `color_idx` sequence 1..6, then 0.
